// File: rtl/dm_ldu_pkg.sv
// dm_ldu_pkg: shared load-type codes, FSM state encoding and alignment helpers for dm_load_unit
//   LD_* codes are also the RF write-port decode (LD_NONE = no write).
package dm_ldu_pkg;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_W    = 3'b001;
    localparam logic [2:0] LD_H    = 3'b010;
    localparam logic [2:0] LD_B    = 3'b011;
    localparam logic [2:0] LD_HU   = 3'b100;
    localparam logic [2:0] LD_BU   = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_e;

    function automatic logic ld_type_ok(input logic [2:0] t);
        return (t == LD_W) || (t == LD_H) || (t == LD_B) || (t == LD_HU) || (t == LD_BU);
    endfunction

    function automatic logic ld_misaligned(input logic [2:0] t, input logic [1:0] off);
        return ((t == LD_W) && (off != 2'b00)) || (((t == LD_H) || (t == LD_HU)) && off[0]);
    endfunction

endpackage

// File: rtl/dm_ldu_lane_extract.sv
// dm_ldu_lane_extract: moves the addressed byte/half of a little-endian word down to bit 0
//   type_i  [2:0]  load type code (LD_*)
//   off_i   [1:0]  byte offset within the word
//   rdata_i [31:0] word read from memory
//   wd_o    [31:0] lane shifted to bit 0, upper bits zero (RF does the extension)
module dm_ldu_lane_extract
    import dm_ldu_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wd_o
);

    logic [31:0] b_sh;
    logic [31:0] h_sh;

    always_comb begin
        b_sh = rdata_i >> {off_i, 3'b000};
        h_sh = rdata_i >> {off_i[1], 4'b0000};
        wd_o = ((type_i == LD_B) || (type_i == LD_BU)) ? {24'd0, b_sh[7:0]} :
               ((type_i == LD_H) || (type_i == LD_HU)) ? {16'd0, h_sh[15:0]} : rdata_i;
    end

endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: single-outstanding load path from execute to the RF write port over req/gnt/rvalid
//   clk_i, rst_ni                    clock, async active-low reset
//   ld_valid_i/ld_ready_o            load request handshake; ld_type_i, ld_addr_i, ld_rd_i captured on accept
//   mem_req_o/mem_addr_o/mem_gnt_i   word-aligned read request, held until granted
//   mem_rvalid_i/mem_rdata_i         read response, only honoured in WAIT
//   wb_rfwr_o/wb_a3_o/wb_wd_o        one-cycle RF write (rfwr 000 = no write)
//   busy_o                           FSM not idle
//   ld_misalign_o, ld_timeout_o      one-cycle error pulses
//   Optional watchdog: define DM_LDU_TIMEOUT_EN to abort after TIMEOUT cycles in REQ+WAIT.
module dm_load_unit
    import dm_ldu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [2:0]        ld_type_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [4:0]        ld_rd_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [2:0]        wb_rfwr_o,
    output logic [4:0]        wb_a3_o,
    output logic [31:0]       wb_wd_o,
    output logic              busy_o,
    output logic              ld_misalign_o,
    output logic              ld_timeout_o
);

    state_e            state_q, state_d;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        rd_q;
    logic [31:0]       wd_q;
    logic              misalign_q;
    logic [31:0]       lane_wd;
    logic              accept;
    logic              to_hit;

    assign accept = ld_valid_i & ld_ready_o;

    dm_ldu_lane_extract u_lane (
        .type_i  (type_q),
        .off_i   (addr_q[1:0]),
        .rdata_i (mem_rdata_i),
        .wd_o    (lane_wd)
    );

`ifdef DM_LDU_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    // Counter restarts on every accept, so it is zero on the first REQ cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= accept ? '0 : ((state_q == S_REQ) || (state_q == S_WAIT)) ? cnt_q + 1'b1 : cnt_q;
            timeout_q <= ((state_q == S_REQ) || (state_q == S_WAIT)) && to_hit;
        end
    end

    assign to_hit       = (cnt_q == CW'(TIMEOUT - 1));
    assign ld_timeout_o = timeout_q;
`else
    // Watchdog absent: never fires; TIMEOUT is only referenced to keep it bound.
    assign to_hit       = (TIMEOUT != 0) & 1'b0;
    assign ld_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Invalid or misaligned requests are accepted but never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (accept && ld_type_ok(ld_type_i) && !ld_misaligned(ld_type_i, ld_addr_i[1:0])) ? S_REQ : S_IDLE;
            S_REQ:   state_d = to_hit ? S_IDLE : mem_gnt_i ? S_WAIT : S_REQ;
            S_WAIT:  state_d = to_hit ? S_IDLE : mem_rvalid_i ? S_WB : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready_o    = rst_ni && (state_q == S_IDLE);
        mem_req_o     = (state_q == S_REQ);
        mem_addr_o    = (state_q == S_REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        busy_o        = (state_q != S_IDLE);
        wb_rfwr_o     = ((state_q == S_WB) && (rd_q != 5'd0)) ? type_q : LD_NONE;
        wb_a3_o       = (state_q == S_WB) ? rd_q : 5'd0;
        wb_wd_o       = (state_q == S_WB) ? wd_q : 32'd0;
        ld_misalign_o = misalign_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            type_q     <= LD_NONE;
            addr_q     <= '0;
            rd_q       <= 5'd0;
            wd_q       <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                type_q <= ld_type_i;
                addr_q <= ld_addr_i;
                rd_q   <= ld_rd_i;
            end
            if ((state_q == S_WAIT) && mem_rvalid_i) begin
                wd_q <= lane_wd;
            end
            misalign_q <= accept && ld_type_ok(ld_type_i) && ld_misaligned(ld_type_i, ld_addr_i[1:0]);
        end
    end

endmodule

// File: tb/tb_dm_load_unit.sv
// tb_dm_load_unit: directed self-checking bench for dm_load_unit
//   Inputs change 1 time unit after each rising edge; outputs are sampled at that point.
module tb_dm_load_unit;
    import dm_ldu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_type = 3'b000;
    logic [31:0] ld_addr = 32'd0;
    logic [4:0]  ld_rd = 5'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [2:0]  wb_rfwr;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        busy;
    logic        ld_misalign;
    logic        ld_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    logic        o_rdy, o_req, o_rdy_after;
    logic [31:0] o_maddr, o_wd;
    logic [2:0]  o_rfwr;
    logic [4:0]  o_a3;

    always #5 clk = ~clk;

    dm_load_unit #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ld_valid_i   (ld_valid),
        .ld_ready_o   (ld_ready),
        .ld_type_i    (ld_type),
        .ld_addr_i    (ld_addr),
        .ld_rd_i      (ld_rd),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .wb_rfwr_o    (wb_rfwr),
        .wb_a3_o      (wb_a3),
        .wb_wd_o      (wb_wd),
        .busy_o       (busy),
        .ld_misalign_o(ld_misalign),
        .ld_timeout_o (ld_timeout)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fastest legal transaction: accept at T, gnt at T+1, rvalid at T+2, WB at T+3; returns at T+4.
    task automatic fast_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd, input logic [31:0] rdata,
                             output logic rdy, output logic req, output logic [31:0] maddr,
                             output logic [2:0] rfwr, output logic [4:0] a3, output logic [31:0] wd, output logic rdy_after);
        ld_valid = 1'b1; ld_type = t; ld_addr = a; ld_rd = rd;
        rdy = ld_ready;
        cyc();
        ld_valid = 1'b0;
        req = mem_req; maddr = mem_addr;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        cyc();
        mem_rvalid = 1'b0;
        rfwr = wb_rfwr; a3 = wb_a3; wd = wb_wd;
        cyc();
        rdy_after = ld_ready;
    endtask

    task automatic test_reset();
        ld_valid = 1'b1; ld_type = LD_W;
        #2;
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset ld_ready: got %b want 0", ld_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
        n_cmp++; if ({busy, wb_rfwr, wb_wd, ld_misalign, ld_timeout} !== 38'd0) begin n_bad++; $display("FAIL reset outputs: got busy=%b rfwr=%b wd=%h mis=%b to=%b want all 0", busy, wb_rfwr, wb_wd, ld_misalign, ld_timeout); end
        ld_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL post-reset ld_ready: got %b want 1", ld_ready); end
    endtask

    task automatic test_lw();
        fast_load(LD_W, 32'h10, 5'd5, 32'hDEADBEEF, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if (o_req !== 1'b1) begin n_bad++; $display("FAIL lw mem_req T+1: got %b want 1", o_req); end
        n_cmp++; if (o_maddr !== 32'h10) begin n_bad++; $display("FAIL lw mem_addr: got %h want 00000010", o_maddr); end
        n_cmp++; if (o_rfwr !== 3'b001) begin n_bad++; $display("FAIL lw rfwr: got %b want 001", o_rfwr); end
        n_cmp++; if (o_a3 !== 5'd5) begin n_bad++; $display("FAIL lw a3: got %0d want 5", o_a3); end
        n_cmp++; if (o_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw wd: got %h want deadbeef", o_wd); end
        n_cmp++; if ({o_rdy_after, wb_rfwr} !== 4'b1000) begin n_bad++; $display("FAIL lw T+4 ready/rfwr: got %b/%b want 1/000", o_rdy_after, wb_rfwr); end
    endtask

    task automatic test_lanes();
        fast_load(LD_B, 32'h13, 5'd7, 32'h80AA55CC, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if (o_maddr !== 32'h10) begin n_bad++; $display("FAIL lb mem_addr aligned: got %h want 00000010", o_maddr); end
        n_cmp++; if ({o_rfwr, o_wd} !== {3'b011, 32'h00000080}) begin n_bad++; $display("FAIL lb 0x13: got %b/%h want 011/00000080", o_rfwr, o_wd); end
        fast_load(LD_HU, 32'h12, 5'd7, 32'h80AA55CC, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if ({o_rfwr, o_wd} !== {3'b100, 32'h000080AA}) begin n_bad++; $display("FAIL lhu 0x12: got %b/%h want 100/000080aa", o_rfwr, o_wd); end
        fast_load(LD_H, 32'h10, 5'd8, 32'h80AA55CC, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if ({o_rfwr, o_wd} !== {3'b010, 32'h000055CC}) begin n_bad++; $display("FAIL lh 0x10: got %b/%h want 010/000055cc", o_rfwr, o_wd); end
        fast_load(LD_BU, 32'h11, 5'd9, 32'h80AA55CC, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if ({o_rfwr, o_wd} !== {3'b101, 32'h00000055}) begin n_bad++; $display("FAIL lbu 0x11: got %b/%h want 101/00000055", o_rfwr, o_wd); end
        fast_load(LD_B, 32'h12, 5'd10, 32'h80AA55CC, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if ({o_rfwr, o_wd} !== {3'b011, 32'h000000AA}) begin n_bad++; $display("FAIL lb 0x12: got %b/%h want 011/000000aa", o_rfwr, o_wd); end
    endtask

    task automatic test_misalign();
        int reqs = 0;
        int wbs = 0;
        ld_valid = 1'b1; ld_type = LD_H; ld_addr = 32'h21; ld_rd = 5'd3;
        cyc();
        ld_valid = 1'b0;
        n_cmp++; if ({ld_misalign, mem_req, busy} !== 3'b100) begin n_bad++; $display("FAIL lh misalign T+1 mis/req/busy: got %b%b%b want 100", ld_misalign, mem_req, busy); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (mem_req) reqs++;
            if (wb_rfwr != 3'b000) wbs++;
            if (i == 0) begin
                n_cmp++; if (ld_misalign !== 1'b0) begin n_bad++; $display("FAIL lh misalign pulse width: got %b at T+2 want 0", ld_misalign); end
            end
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL lh misalign mem_req cycles: got %0d want 0", reqs); end
        n_cmp++; if (wbs !== 0) begin n_bad++; $display("FAIL lh misalign writebacks: got %0d want 0", wbs); end
        ld_valid = 1'b1; ld_type = LD_W; ld_addr = 32'h22;
        cyc();
        ld_valid = 1'b0;
        n_cmp++; if ({ld_misalign, mem_req} !== 2'b10) begin n_bad++; $display("FAIL lw 0x22 misalign/req: got %b%b want 10", ld_misalign, mem_req); end
        cyc();
    endtask

    task automatic test_invalid();
        ld_valid = 1'b1; ld_type = 3'b111; ld_addr = 32'h40; ld_rd = 5'd4;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL invalid ld_ready at accept: got %b want 1", ld_ready); end
        cyc();
        ld_valid = 1'b0;
        n_cmp++; if ({busy, mem_req, ld_misalign, ld_ready} !== 4'b0001) begin n_bad++; $display("FAIL invalid busy/req/mis/ready: got %b%b%b%b want 0001", busy, mem_req, ld_misalign, ld_ready); end
        cyc();
    endtask

    task automatic test_slow_gnt();
        int bad_hold = 0;
        int extra_wb = 0;
        ld_valid = 1'b1; ld_type = LD_W; ld_addr = 32'h44; ld_rd = 5'd9;
        cyc();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = (i == 1); mem_rdata = 32'h11111111;
            if (mem_req !== 1'b1 || mem_addr !== 32'h44 || ld_ready !== 1'b0) bad_hold++;
            cyc();
        end
        mem_rvalid = 1'b0;
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL slow req/addr hold: got %0d bad cycles want 0", bad_hold); end
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin n_bad++; $display("FAIL slow req at gnt: got %b/%h want 1/00000044", mem_req, mem_addr); end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        n_cmp++; if ({mem_req, ld_ready, busy} !== 3'b001) begin n_bad++; $display("FAIL slow WAIT req/ready/busy: got %b%b%b want 001", mem_req, ld_ready, busy); end
        cyc(); cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        cyc();
        mem_rvalid = 1'b0;
        n_cmp++; if ({wb_rfwr, wb_a3, wb_wd, ld_ready} !== {3'b001, 5'd9, 32'hCAFEF00D, 1'b0}) begin n_bad++; $display("FAIL slow WB: got %b/%0d/%h ready=%b want 001/9/cafef00d ready=0", wb_rfwr, wb_a3, wb_wd, ld_ready); end
        cyc();
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL slow ready after WB: got %b want 1", ld_ready); end
        for (int i = 0; i < 4; i++) begin
            if (wb_rfwr != 3'b000) extra_wb++;
            cyc();
        end
        n_cmp++; if (extra_wb !== 0) begin n_bad++; $display("FAIL slow extra WB: got %0d want 0", extra_wb); end
    endtask

    task automatic test_reset_mid();
        int wbs = 0;
        ld_valid = 1'b1; ld_type = LD_W; ld_addr = 32'h80; ld_rd = 5'd3;
        cyc();
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_req, busy, ld_ready} !== 3'b000) begin n_bad++; $display("FAIL reset in REQ req/busy/ready: got %b%b%b want 000", mem_req, busy, ld_ready); end
        cyc();
        rst_n = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h84; ld_rd = 5'd4;
        cyc();
        ld_valid = 1'b0; mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_req, busy} !== 2'b00) begin n_bad++; $display("FAIL reset in WAIT req/busy: got %b%b want 00", mem_req, busy); end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        cyc();
        rst_n = 1'b1;
        cyc();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wb_rfwr != 3'b000) wbs++;
            cyc();
        end
        n_cmp++; if (wbs !== 0) begin n_bad++; $display("FAIL reset mid WB count: got %0d want 0", wbs); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL reset mid ready after release: got %b want 1", ld_ready); end
    endtask

    task automatic test_rd0();
        fast_load(LD_W, 32'h90, 5'd0, 32'hA5A5A5A5, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if (o_req !== 1'b1) begin n_bad++; $display("FAIL rd0 mem access: got req=%b want 1", o_req); end
        n_cmp++; if (o_rfwr !== 3'b000) begin n_bad++; $display("FAIL rd0 rfwr: got %b want 000", o_rfwr); end
    endtask

    task automatic test_back_to_back();
        fast_load(LD_W, 32'h100, 5'd11, 32'h01020304, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        fast_load(LD_BU, 32'h107, 5'd12, 32'hF1E2D3C4, o_rdy, o_req, o_maddr, o_rfwr, o_a3, o_wd, o_rdy_after);
        n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b ready at T+4: got %b want 1", o_rdy); end
        n_cmp++; if ({o_maddr, o_rfwr, o_a3, o_wd} !== {32'h104, 3'b101, 5'd12, 32'h000000F1}) begin n_bad++; $display("FAIL b2b second load: got %h/%b/%0d/%h want 00000104/101/12/000000f1", o_maddr, o_rfwr, o_a3, o_wd); end
    endtask

`ifdef DM_LDU_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        int wbs = 0;
        ld_valid = 1'b1; ld_type = LD_W; ld_addr = 32'h200; ld_rd = 5'd6;
        cyc();
        ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req !== 1'b1 || ld_timeout !== 1'b0) early++;
            cyc();
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL timeout early abort: got %0d bad cycles want 0", early); end
        n_cmp++; if ({ld_timeout, mem_req, busy} !== 3'b100) begin n_bad++; $display("FAIL timeout pulse/req/busy: got %b%b%b want 100", ld_timeout, mem_req, busy); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (wb_rfwr != 3'b000 || ld_timeout) wbs++;
        end
        n_cmp++; if (wbs !== 0) begin n_bad++; $display("FAIL timeout aftermath WB/pulse: got %0d want 0", wbs); end
    endtask
`else
    task automatic test_timeout();
        int drop = 0;
        ld_valid = 1'b1; ld_type = LD_W; ld_addr = 32'h200; ld_rd = 5'd6;
        cyc();
        ld_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req !== 1'b1 || ld_timeout !== 1'b0) drop++;
            cyc();
        end
        n_cmp++; if (drop !== 0) begin n_bad++; $display("FAIL no-watchdog long stall: got %0d bad cycles want 0", drop); end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        cyc();
        mem_rvalid = 1'b0;
        n_cmp++; if ({wb_rfwr, wb_wd} !== {3'b001, 32'h0BADF00D}) begin n_bad++; $display("FAIL no-watchdog WB: got %b/%h want 001/0badf00d", wb_rfwr, wb_wd); end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_lanes();
        test_misalign();
        test_invalid();
        test_slow_gnt();
        test_reset_mid();
        test_rd0();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
